// File: rtl/cruise_pkg.sv
// ---------------------------------------------------------------------------
// cruise_pkg
//   Shared definitions for the cruise speed controller: FSM state encoding,
//   default speed window and step, timing defaults, and saturating target
//   step helpers.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package cruise_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'b00,
        ST_STANDBY  = 2'b01,
        ST_CRUISE   = 2'b10,
        ST_OVERRIDE = 2'b11
    } cc_state_t;

    localparam logic [7:0] DEF_MIN_SPEED     = 8'd40;
    localparam logic [7:0] DEF_MAX_SPEED     = 8'd200;
    localparam logic [7:0] DEF_STEP          = 8'd2;
    localparam int         DEF_REPEAT_CYCLES = 16;
    localparam int         DEF_DROP_CYCLES   = 8;

    // Raise target by step, clamped to max. 9-bit sum so it cannot wrap.
    function automatic logic [7:0] step_up(input logic [7:0] tgt,
                                           input logic [7:0] step,
                                           input logic [7:0] max);
        logic [8:0] sum;
        sum = {1'b0, tgt} + {1'b0, step};
        return (sum > {1'b0, max}) ? max : sum[7:0];
    endfunction

    // Lower target by step, clamped to min. Compare before subtracting.
    function automatic logic [7:0] step_down(input logic [7:0] tgt,
                                             input logic [7:0] step,
                                             input logic [7:0] min);
        logic [8:0] floor_sum;
        floor_sum = {1'b0, min} + {1'b0, step};
        return ({1'b0, tgt} < floor_sum) ? min : (tgt - step);
    endfunction

endpackage

// File: rtl/eight_bit_comparator.sv
// ---------------------------------------------------------------------------
// eight_bit_comparator
//   Unsigned magnitude comparator. Operands are declared [0:7], so bit 0 is
//   the MSB; a [7:0] vector connected straight to the port lands MSB-first.
//   Ports:
//     a, b : operands [0:7]
//     lt   : a <  b
//     eq   : a == b
//     gt   : a >  b
// ---------------------------------------------------------------------------
module eight_bit_comparator (
    input  logic [0:7] a,
    input  logic [0:7] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule

// File: rtl/cruise_speed_controller.sv
// ---------------------------------------------------------------------------
// cruise_speed_controller
//   Cruise-control sequencer. Holds a target speed, compares it every cycle
//   against the measured speed and issues registered throttle up/down
//   requests while cruising.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   OFF       | master switch off, target cleared
//   STANDBY   | armed, waiting for set or resume
//   CRUISE    | regulating speed toward target, target adjustable
//   OVERRIDE  | driver accelerating, throttle requests suppressed
//
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     cc_on               : master enable (level)
//     set_btn, resume_btn : capture / re-engage (edge-detected)
//     inc_btn, dec_btn    : target adjust, press = 1 step, hold = repeat
//     brake, accel        : pedals (level)
//     speed               : measured speed
//     target_speed        : current target
//     target_valid        : target holds a legal captured value
//     cc_active           : state is CRUISE or OVERRIDE
//     throttle_up/down    : throttle requests (mutually exclusive)
//     state_o             : FSM state encoding
// ---------------------------------------------------------------------------
module cruise_speed_controller
    import cruise_pkg::*;
#(
    parameter logic [7:0]  MIN_SPEED     = DEF_MIN_SPEED,
    parameter logic [7:0]  MAX_SPEED     = DEF_MAX_SPEED,
    parameter logic [7:0]  STEP          = DEF_STEP,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned DROP_CYCLES   = DEF_DROP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cc_on,
    input  logic       set_btn,
    input  logic       resume_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       brake,
    input  logic       accel,
    input  logic [7:0] speed,
    output logic [7:0] target_speed,
    output logic       target_valid,
    output logic       cc_active,
    output logic       throttle_up,
    output logic       throttle_down,
    output logic [1:0] state_o
);

    localparam int RPT_W  = $clog2(REPEAT_CYCLES);
    localparam int DROP_W = $clog2(DROP_CYCLES + 1);
    localparam logic [RPT_W-1:0]  RPT_RELOAD = RPT_W'(REPEAT_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_LAST  = DROP_W'(DROP_CYCLES - 1);

    cc_state_t         state;
    logic              set_q, resume_q, inc_q, dec_q;
    logic              set_edge, resume_edge, inc_edge, dec_edge;
    logic              in_range, below_min;
    logic              cmp_lt, cmp_eq, cmp_gt;
    logic              drop_hit, cruise_adj, step_now;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [DROP_W-1:0] drop_cnt;

    eight_bit_comparator u_cmp (
        .a  (speed),
        .b  (target_speed),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    assign set_edge    = set_btn    & ~set_q;
    assign resume_edge = resume_btn & ~resume_q;
    assign inc_edge    = inc_btn    & ~inc_q;
    assign dec_edge    = dec_btn    & ~dec_q;

    assign in_range  = (speed >= MIN_SPEED) && (speed <= MAX_SPEED);
    assign below_min = (speed < MIN_SPEED);

    assign drop_hit = (state == ST_CRUISE) && below_min && (drop_cnt == DROP_LAST);

    // True only when the CRUISE branch falls through to inc/dec handling,
    // i.e. nothing of higher priority acts this cycle.
    assign cruise_adj = cc_on && (state == ST_CRUISE) && !brake && !accel &&
                        !drop_hit && !(set_edge && in_range);

    // rpt_cnt reaching zero while held marks the next auto-repeat step.
    assign step_now = cruise_adj && (inc_btn ^ dec_btn) &&
                      (inc_edge || dec_edge || (rpt_cnt == '0));

    assign state_o   = state;
    assign cc_active = state[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q    <= 1'b0;
            resume_q <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            set_q    <= set_btn;
            resume_q <= resume_btn;
            inc_q    <= inc_btn;
            dec_q    <= dec_btn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
        end else if (!cruise_adj) begin
            rpt_cnt <= RPT_RELOAD;
        end else if (inc_btn && dec_btn) begin
            rpt_cnt <= '0;
        end else if (inc_edge || dec_edge) begin
            rpt_cnt <= RPT_RELOAD;
        end else if (inc_btn || dec_btn) begin
            rpt_cnt <= (rpt_cnt == '0) ? RPT_RELOAD : rpt_cnt - RPT_W'(1);
        end else begin
            rpt_cnt <= RPT_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if ((state == ST_CRUISE) && below_min && !drop_hit) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end else begin
            drop_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_OFF;
            target_speed  <= '0;
            target_valid  <= 1'b0;
            throttle_up   <= 1'b0;
            throttle_down <= 1'b0;
        end else begin
            throttle_up   <= 1'b0;
            throttle_down <= 1'b0;
            if (!cc_on) begin
                state        <= ST_OFF;
                target_speed <= '0;
                target_valid <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: state <= ST_STANDBY;
                    ST_STANDBY: begin
                        if (!brake) begin
                            if (set_edge && in_range) begin
                                state        <= ST_CRUISE;
                                target_speed <= speed;
                                target_valid <= 1'b1;
                            end else if (resume_edge && target_valid) begin
                                state <= ST_CRUISE;
                            end
                        end
                    end
                    ST_CRUISE: begin
                        if (brake) begin
                            state <= ST_STANDBY;
                        end else if (accel) begin
                            state <= ST_OVERRIDE;
                        end else if (drop_hit) begin
                            state <= ST_STANDBY;
                        end else begin
                            // Throttle is only driven while staying in CRUISE so
                            // it never lags a state exit by a cycle.
                            throttle_up   <= cmp_lt & ~cmp_eq;
                            throttle_down <= cmp_gt & ~cmp_eq;
                            if (set_edge && in_range) begin
                                target_speed <= speed;
                            end else if (step_now) begin
                                target_speed <= inc_btn ?
                                    step_up(target_speed, STEP, MAX_SPEED) :
                                    step_down(target_speed, STEP, MIN_SPEED);
                            end
                        end
                    end
                    ST_OVERRIDE: begin
                        if (brake) begin
                            state <= ST_STANDBY;
                        end else if (!accel) begin
                            state <= ST_CRUISE;
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cruise_speed_controller.sv
// ---------------------------------------------------------------------------
// tb_cruise_speed_controller
//   Scoreboarded bench: each clock, a behavioural model of the controller
//   computes the outputs expected after the edge and pushes them to a queue;
//   after the edge the entry is popped and compared. Directed constant checks
//   cover the specific scenarios (capture, repeat timing, saturation, reset).
// ---------------------------------------------------------------------------
module tb_cruise_speed_controller;

    logic       clk = 1'b0;
    logic       rst_n, cc_on, set_btn, resume_btn, inc_btn, dec_btn, brake, accel;
    logic [7:0] speed;
    logic [7:0] target_speed;
    logic       target_valid, cc_active, throttle_up, throttle_down;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    cruise_speed_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cc_on         (cc_on),
        .set_btn       (set_btn),
        .resume_btn    (resume_btn),
        .inc_btn       (inc_btn),
        .dec_btn       (dec_btn),
        .brake         (brake),
        .accel         (accel),
        .speed         (speed),
        .target_speed  (target_speed),
        .target_valid  (target_valid),
        .cc_active     (cc_active),
        .throttle_up   (throttle_up),
        .throttle_down (throttle_down),
        .state_o       (state_o)
    );

    typedef struct {
        int tgt;
        int valid;
        int st;
        int act;
        int up;
        int dn;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // model state: 0 OFF, 1 STANDBY, 2 CRUISE, 3 OVERRIDE
    int m_st, m_tgt, m_valid, m_up, m_dn, m_since, m_drop;
    bit p_set, p_res, p_inc, p_dec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tgt = 0; m_valid = 0; m_up = 0; m_dn = 0; m_since = 0; m_drop = 0;
        p_set = 0; p_res = 0; p_inc = 0; p_dec = 0;
    endtask

    function automatic int bump(input int t, input bit up);
        if (up) return (t + 2 > 200) ? 200 : t + 2;
        return (t - 2 < 40) ? 40 : t - 2;
    endfunction

    task automatic model_step();
        bit se, re, ie, de, inr, below;
        int ns, nt, nv, nu, nd, nsince, ndrop;
        se    = set_btn    && !p_set;
        re    = resume_btn && !p_res;
        ie    = inc_btn    && !p_inc;
        de    = dec_btn    && !p_dec;
        inr   = (speed >= 40) && (speed <= 200);
        below = (speed < 40);
        ns = m_st; nt = m_tgt; nv = m_valid; nu = 0; nd = 0; nsince = 0;
        ndrop = (m_st == 2 && below) ? m_drop + 1 : 0;
        if (!cc_on) begin
            ns = 0; nt = 0; nv = 0;
        end else begin
            case (m_st)
                0: ns = 1;
                1: if (!brake) begin
                       if (se && inr) begin ns = 2; nt = speed; nv = 1; end
                       else if (re && m_valid != 0) ns = 2;
                   end
                2: if (brake) ns = 1;
                   else if (accel) ns = 3;
                   else if (below && m_drop == 7) ns = 1;
                   else begin
                       nu = (speed < m_tgt) ? 1 : 0;
                       nd = (speed > m_tgt) ? 1 : 0;
                       if (se && inr) nt = speed;
                       else if (inc_btn && dec_btn) nsince = 15;
                       else if (inc_btn || dec_btn) begin
                           if (ie || de) begin
                               nt = bump(m_tgt, inc_btn);
                               nsince = 0;
                           end else begin
                               nsince = m_since + 1;
                               if (nsince == 16) begin
                                   nt = bump(m_tgt, inc_btn);
                                   nsince = 0;
                               end
                           end
                       end
                   end
                default: if (brake) ns = 1;
                         else if (!accel) ns = 2;
            endcase
        end
        m_st = ns; m_tgt = nt; m_valid = nv; m_up = nu; m_dn = nd;
        m_since = nsince; m_drop = ndrop;
        p_set = set_btn; p_res = resume_btn; p_inc = inc_btn; p_dec = dec_btn;
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        e.tgt = m_tgt; e.valid = m_valid; e.st = m_st;
        e.act = (m_st >= 2) ? 1 : 0; e.up = m_up; e.dn = m_dn;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("sb_tgt",   32'(target_speed),  32'(e.tgt));
            chk("sb_valid", 32'(target_valid),  32'(e.valid));
            chk("sb_state", 32'(state_o),       32'(e.st));
            chk("sb_active",32'(cc_active),     32'(e.act));
            chk("sb_up",    32'(throttle_up),   32'(e.up));
            chk("sb_dn",    32'(throttle_down), 32'(e.dn));
            chk("sb_excl",  32'(throttle_up & throttle_down), 32'd0);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_pulse(input logic [7:0] spd);
        speed = spd; set_btn = 1'b1; cyc();
        set_btn = 1'b0; cyc();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_tgt"},   32'(target_speed),  32'd0);
        chk({tag, "_valid"}, 32'(target_valid),  32'd0);
        chk({tag, "_state"}, 32'(state_o),       32'd0);
        chk({tag, "_act"},   32'(cc_active),     32'd0);
        chk({tag, "_up"},    32'(throttle_up),   32'd0);
        chk({tag, "_dn"},    32'(throttle_down), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cc_on = 1'b0; set_btn = 1'b0; resume_btn = 1'b0;
        inc_btn = 1'b0; dec_btn = 1'b0; brake = 1'b0; accel = 1'b0; speed = 8'd0;
        model_reset();
        #12;
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: capture and throttle direction
        cc_on = 1'b1; cyc();
        chk("t1_standby", 32'(state_o), 32'd1);
        speed = 8'd60; cyc();
        set_btn = 1'b1; cyc();
        chk("t1_cruise", 32'(state_o), 32'd2);
        chk("t1_tgt60", 32'(target_speed), 32'd60);
        set_btn = 1'b0; cyc();
        speed = 8'd58; cyc();
        chk("t1_up", 32'(throttle_up), 32'd1);
        speed = 8'd60; cyc();
        chk("t1_eq_up", 32'(throttle_up), 32'd0);
        chk("t1_eq_dn", 32'(throttle_down), 32'd0);
        speed = 8'd62; cyc();
        chk("t1_dn", 32'(throttle_down), 32'd1);
        speed = 8'd60; cyc();

        // 2: inc press + auto-repeat, saturation at both ends
        inc_btn = 1'b1; cyc();
        chk("t2_press", 32'(target_speed), 32'd62);
        cycles(15);
        chk("t2_hold15", 32'(target_speed), 32'd62);
        cyc();
        chk("t2_rep1", 32'(target_speed), 32'd64);
        cycles(15);
        cyc();
        chk("t2_rep2", 32'(target_speed), 32'd66);
        cycles(7);
        inc_btn = 1'b0; cyc();
        chk("t2_release", 32'(target_speed), 32'd66);
        set_pulse(8'd200);
        chk("t2_tgt200", 32'(target_speed), 32'd200);
        inc_btn = 1'b1; cyc();
        chk("t2_sat_max", 32'(target_speed), 32'd200);
        inc_btn = 1'b0; cyc();
        dec_btn = 1'b1; cyc();
        chk("t2_dec", 32'(target_speed), 32'd198);
        dec_btn = 1'b0; cyc();
        inc_btn = 1'b1; dec_btn = 1'b1; cyc();
        chk("t2_both", 32'(target_speed), 32'd198);
        inc_btn = 1'b0; dec_btn = 1'b0; cyc();
        set_pulse(8'd40);
        dec_btn = 1'b1; cyc();
        chk("t2_sat_min", 32'(target_speed), 32'd40);
        dec_btn = 1'b0; cyc();
        set_pulse(8'd60);

        // 3: brake then resume
        brake = 1'b1; cyc();
        chk("t3_standby", 32'(state_o), 32'd1);
        chk("t3_tgt_kept", 32'(target_speed), 32'd60);
        brake = 1'b0; cyc();
        resume_btn = 1'b1; cyc();
        chk("t3_resume", 32'(state_o), 32'd2);
        resume_btn = 1'b0; cyc();

        // 4: override ignores inc
        accel = 1'b1; cyc();
        chk("t4_override", 32'(state_o), 32'd3);
        inc_btn = 1'b1; cyc();
        inc_btn = 1'b0; cyc();
        chk("t4_inc_ignored", 32'(target_speed), 32'd60);
        accel = 1'b0; cyc();
        chk("t4_back", 32'(state_o), 32'd2);

        // 5: out-of-range set, cc_on drop, resume without valid target
        cc_on = 1'b0; cyc();
        cc_on = 1'b1; cyc();
        set_pulse(8'd30);
        chk("t5_oor_state", 32'(state_o), 32'd1);
        chk("t5_oor_valid", 32'(target_valid), 32'd0);
        set_pulse(8'd60);
        chk("t5_valid", 32'(target_valid), 32'd1);
        cc_on = 1'b0; cyc();
        chk("t5_off", 32'(state_o), 32'd0);
        chk("t5_off_valid", 32'(target_valid), 32'd0);
        cc_on = 1'b1; cyc();
        resume_btn = 1'b1; cyc();
        resume_btn = 1'b0; cyc();
        chk("t5_no_resume", 32'(state_o), 32'd1);

        // 6: async reset mid-cycle, then low-speed drop-out
        speed = 8'd58;
        set_pulse(8'd60);
        speed = 8'd58; cyc();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cc_on = 1'b1; cyc();
        set_pulse(8'd60);
        speed = 8'd35;
        cycles(7);
        chk("t6_still_cruise", 32'(state_o), 32'd2);
        cyc();
        chk("t6_drop", 32'(state_o), 32'd1);
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
